// File: rtl/board_pkg.sv
// Board object definitions shared by the object matrix and the pixel renderer.
// Holds the object code set, tile geometry, sprite addressing and the sprite
// texel generator used to populate the sprite ROM.
package board_pkg;

    typedef enum logic [3:0] {
        BACKGROUND   = 4'h0,
        PERSIST_WALL = 4'h1,
        STURDY_WALL  = 4'h2,
        BRITTLE_WALL = 4'h3,
        ADDED_MINE   = 4'h4,
        STATIC_MINE  = 4'h5,
        TIME_BOMB    = 4'h6,
        TIME_BOOSTER = 4'h7,
        USER_BOMB    = 4'h8,
        STURDY_EXPL  = 4'h9,
        BRITTLE_EXPL = 4'hA
    } obj_code_e;

    localparam int         TILE_ORDER         = 5;
    localparam logic [7:0] TRANSPARENT_COLOUR = 8'hFF;
    localparam int         SPRITE_ADDR_W      = 15;
    localparam logic [3:0] MAX_OBJ_CODE       = 4'hA;

    // Sprite image generator: address = {sel[4:0], y[4:0], x[4:0]}.
    // The main diagonal (x == y) is transparent; every other texel is
    // {sel[3:0]^y[3:0], x[3:0]} with bit 3 flipped for sel[4], and a
    // result that would collide with the transparent code becomes 8'hFE.
    function automatic logic [7:0] sprite_texel(input logic [SPRITE_ADDR_W-1:0] addr);
        logic [7:0] raw_v;
        raw_v = {addr[13:10] ^ addr[8:5], addr[3:0]} ^ {4'h0, addr[14], 3'b000};
        if (addr[9:5] == addr[4:0]) begin
            return TRANSPARENT_COLOUR;
        end else if (raw_v == TRANSPARENT_COLOUR) begin
            return 8'hFE;
        end else begin
            return raw_v;
        end
    endfunction

endpackage

// File: rtl/board_tile_renderer_rom.sv
// Sprite ROM (32K x 8) with registered read: forms the second pipeline stage.
// Alongside the texel it registers the draw decision so the claim signal is
// aligned with the colour it refers to.
module tile_sprite_rom
    import board_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SPRITE_ADDR_W-1:0] addr,
    input  logic                     claim,
    output logic [7:0]               texel,
    output logic                     draw
);

    logic [7:0] texel_s;

    // Combinational ROM lookup of the addressed texel.
    always_comb begin
        texel_s = sprite_texel(addr);
    end

    // Output register: texel plus draw request (transparent texels never draw).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            texel <= 8'h00;
            draw  <= 1'b0;
        end else begin
            texel <= texel_s;
            draw  <= claim && (texel_s != TRANSPARENT_COLOUR);
        end
    end

endmodule

// File: rtl/board_tile_renderer.sv
// Pixel-side renderer for the board object matrix.
// Stage 1 registers tile offsets, object code and animation phase bit;
// stage 2 is the sprite ROM output register. Latency 2, full throughput.
// Optional build macro BLINK_MINES_EN: mines (codes 4 and 5) are suppressed
// while the animation phase is 1.
module board_tile_renderer
    import board_pkg::*;
#(
    parameter int ANIM_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic [10:0] tile_x,
    input  logic [10:0] tile_y,
    input  logic [3:0]  object,
    input  logic        in_valid,
    input  logic        frame_start,
    output logic [7:0]  rgb,
    output logic        draw_req,
    output logic        out_valid,
    output logic        anim_phase
);

    localparam logic [7:0] LAST_FRAME = 8'(ANIM_FRAMES - 1);

    logic [10:0]           dx_s;
    logic [10:0]           dy_s;
    logic [3:0]            obj_s;
    logic                  phase_bit_s;
    logic                  blank_s;
    logic                  unused_hi_s;

    logic                  s1_valid_r;
    logic [3:0]            s1_obj_r;
    logic                  s1_phase_r;
    logic                  s1_blank_r;
    logic [TILE_ORDER-1:0] s1_off_x_r;
    logic [TILE_ORDER-1:0] s1_off_y_r;
    logic [7:0]            frame_cnt_r;
    logic                  anim_phase_r;
    logic                  out_valid_r;

    logic [SPRITE_ADDR_W-1:0] rom_addr_s;
    logic                     claim_s;

    // Tile offsets, object remap and per-pixel phase/blank decisions.
    always_comb begin
        dx_s        = pixel_x - tile_x;
        dy_s        = pixel_y - tile_y;
        unused_hi_s = ^{dx_s[10:TILE_ORDER], dy_s[10:TILE_ORDER]};
        if (object > MAX_OBJ_CODE) begin
            obj_s = 4'h0;
        end else begin
            obj_s = object;
        end
        case (obj_code_e'(obj_s))
            STURDY_EXPL, BRITTLE_EXPL: phase_bit_s = anim_phase_r;
            default:                   phase_bit_s = 1'b0;
        endcase
`ifdef BLINK_MINES_EN
        case (obj_code_e'(obj_s))
            ADDED_MINE, STATIC_MINE: blank_s = anim_phase_r;
            default:                 blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_obj_r   <= 4'h0;
            s1_phase_r <= 1'b0;
            s1_blank_r <= 1'b0;
            s1_off_x_r <= '0;
            s1_off_y_r <= '0;
        end else begin
            s1_valid_r <= in_valid;
            s1_obj_r   <= obj_s;
            s1_phase_r <= phase_bit_s;
            s1_blank_r <= blank_s;
            s1_off_x_r <= dx_s[TILE_ORDER-1:0];
            s1_off_y_r <= dy_s[TILE_ORDER-1:0];
        end
    end

    // Sprite address and claim condition from stage 1.
    always_comb begin
        rom_addr_s = {s1_obj_r, s1_phase_r, s1_off_y_r, s1_off_x_r};
        claim_s    = s1_valid_r && (s1_obj_r != 4'h0) && !s1_blank_r;
    end

    tile_sprite_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (rom_addr_s),
        .claim (claim_s),
        .texel (rgb),
        .draw  (draw_req)
    );

    // Stage 2 valid register, aligned with the ROM output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= s1_valid_r;
        end
    end

    // Frame counter and animation phase; only frame_start moves them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r  <= 8'h00;
            anim_phase_r <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_r >= LAST_FRAME) begin
                frame_cnt_r  <= 8'h00;
                anim_phase_r <= ~anim_phase_r;
            end else begin
                frame_cnt_r  <= frame_cnt_r + 8'h01;
                anim_phase_r <= anim_phase_r;
            end
        end else begin
            frame_cnt_r  <= frame_cnt_r;
            anim_phase_r <= anim_phase_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign anim_phase = anim_phase_r;

endmodule

// File: tb/tb_board_tile_renderer.sv
// Self-checking bench for board_tile_renderer: hand-computed vector table
// plus sequences for streams, animation phase, boundary and reset cases.
module tb_board_tile_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] pixel_x, pixel_y, tile_x, tile_y;
    logic [3:0]  object;
    logic        in_valid, frame_start;
    logic [7:0]  rgb;
    logic        draw_req, out_valid, anim_phase;

    board_tile_renderer #(.ANIM_FRAMES(8)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .tile_x(tile_x), .tile_y(tile_y), .object(object), .in_valid(in_valid),
        .frame_start(frame_start), .rgb(rgb), .draw_req(draw_req),
        .out_valid(out_valid), .anim_phase(anim_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] rgb;
        logic       draw;
    } exp_t;

    typedef struct {
        logic       v;
        logic [10:0] px, py, tx, ty;
        logic [3:0] ob;
        logic [7:0] e_rgb;
        logic       e_draw;
    } vec_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_phase = 1'b0;
    int   m_cnt = 0;
    bit   blink;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Independent model of the sprite image content.
    function automatic logic [7:0] model_texel(input logic [4:0] sel, input logic [4:0] y, input logic [4:0] x);
        logic [3:0] hi, lo;
        if (x == y) return 8'hFF;
        hi = sel[3:0] ^ y[3:0];
        lo = sel[4] ? (x[3:0] ^ 4'h8) : x[3:0];
        if ({hi, lo} == 8'hFF) return 8'hFE;
        return {hi, lo};
    endfunction

    function automatic exp_t model(input logic v, input logic [10:0] px, py, tx, ty, input logic [3:0] ob);
        exp_t e;
        logic [3:0]  o;
        logic        pb;
        logic [10:0] dx, dy;
        o  = (ob >= 4'hB) ? 4'h0 : ob;
        pb = (o == 4'h9 || o == 4'hA) ? m_phase : 1'b0;
        dx = px - tx;
        dy = py - ty;
        e.v    = v;
        e.rgb  = model_texel({o, pb}, dy[4:0], dx[4:0]);
        e.draw = v && (o != 4'h0) && (e.rgb != 8'hFF) && !(blink && m_phase && (o == 4'h4 || o == 4'h5));
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        cmp("anim_phase", {7'b0, anim_phase}, {7'b0, m_phase});
        if (sbq.size() == 2) begin
            e = sbq.pop_front();
            cmp("out_valid", {7'b0, out_valid}, {7'b0, e.v});
            if (e.v) begin
                cmp("rgb", rgb, e.rgb);
                cmp("draw_req", {7'b0, draw_req}, {7'b0, e.draw});
            end else begin
                cmp("draw_req_bubble", {7'b0, draw_req}, 8'h00);
            end
        end
    endtask

    // Drive one pixel (no wait); push expectation, then advance the phase model.
    task automatic drive(input logic v, input logic [10:0] px, py, tx, ty, input logic [3:0] ob,
                         input logic fs, input bit use_e, input logic [7:0] er, input logic ed);
        exp_t e;
        pixel_x = px; pixel_y = py; tile_x = tx; tile_y = ty;
        object = ob; in_valid = v; frame_start = fs;
        e = model(v, px, py, tx, ty, ob);
        if (use_e) begin
            e.rgb  = er;
            e.draw = ed;
        end
        sbq.push_back(e);
        if (fs) begin
            if (m_cnt == 7) begin
                m_cnt = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [10:0] px, py, tx, ty, input logic [3:0] ob, input logic fs);
        @(negedge clk);
        check_out();
        drive(v, px, py, tx, ty, ob, fs, 1'b0, 8'h00, 1'b0);
    endtask

    vec_t vt[11];

    initial begin
`ifdef BLINK_MINES_EN
        blink = 1'b1;
`else
        blink = 1'b0;
`endif
        // {v, px, py, tx, ty, obj, exp rgb, exp draw}
        vt[0]  = '{1'b1, 11'h045, 11'h07A, 11'h040, 11'h060, 4'h2, 8'hE5, 1'b1};
        vt[1]  = '{1'b1, 11'h003, 11'h003, 11'h000, 11'h000, 4'h3, 8'hFF, 1'b0};
        vt[2]  = '{1'b1, 11'h007, 11'h002, 11'h000, 11'h000, 4'h0, 8'h27, 1'b0};
        vt[3]  = '{1'b1, 11'h001, 11'h002, 11'h000, 11'h000, 4'hC, 8'h21, 1'b0};
        vt[4]  = '{1'b1, 11'h002, 11'h010, 11'h7FF, 11'h001, 4'h1, 8'hD3, 1'b1};
        vt[5]  = '{1'b1, 11'h021, 11'h024, 11'h020, 11'h020, 4'h9, 8'h69, 1'b1};
        vt[6]  = '{1'b0, 11'h000, 11'h000, 11'h000, 11'h000, 4'h2, 8'h00, 1'b0};
        vt[7]  = '{1'b1, 11'h042, 11'h046, 11'h040, 11'h040, 4'hA, 8'h2A, 1'b1};
        vt[8]  = '{1'b1, 11'h00F, 11'h000, 11'h000, 11'h000, 4'h4, 8'h8F, 1'b1};
        vt[9]  = '{1'b1, 11'h00F, 11'h001, 11'h000, 11'h000, 4'h7, 8'hFE, 1'b1};
        vt[10] = '{1'b1, 11'h01F, 11'h01E, 11'h000, 11'h000, 4'h5, 8'h4F, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        cmp("reset_rgb", rgb, 8'h00);
        cmp("reset_draw", {7'b0, draw_req}, 8'h00);
        cmp("reset_valid", {7'b0, out_valid}, 8'h00);
        cmp("reset_phase", {7'b0, anim_phase}, 8'h00);
        sbq.delete();
        rst_n = 1'b1;

        // Table of hand-computed vectors, back to back.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check_out();
            drive(vt[i].v, vt[i].px, vt[i].py, vt[i].tx, vt[i].ty, vt[i].ob, 1'b0, 1'b1, vt[i].e_rgb, vt[i].e_draw);
        end

        // Background stream with random bubbles.
        for (int i = 0; i < 10; i++)
            cyc(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
                11'h000, 11'h000, 4'h0, 1'b0);

        // Eight frame pulses toggle the phase to 1.
        for (int i = 0; i < 8; i++) cyc(1'b0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b1);
        cyc(1'b1, 11'h021, 11'h024, 11'h020, 11'h020, 4'h9, 1'b0);   // phase-1 sprite: 79
        cyc(1'b1, 11'h045, 11'h07A, 11'h040, 11'h060, 4'h2, 1'b0);   // unaffected: E5
        cyc(1'b1, 11'h01F, 11'h01E, 11'h000, 11'h000, 4'h5, 1'b0);   // mine, blink-dependent
        cyc(1'b1, 11'h00F, 11'h000, 11'h000, 11'h000, 4'h4, 1'b0);
        cyc(1'b1, 11'h042, 11'h046, 11'h040, 11'h040, 4'hA, 1'b0);   // phase-1 sprite: 3A

        // Reset while out_valid is high and phase is 1.
        @(negedge clk);
        check_out();
        rst_n = 1'b0;
        #1;
        cmp("rst_mid_valid", {7'b0, out_valid}, 8'h00);
        cmp("rst_mid_draw", {7'b0, draw_req}, 8'h00);
        cmp("rst_mid_phase", {7'b0, anim_phase}, 8'h00);
        sbq.delete();
        m_phase = 1'b0;
        m_cnt = 0;
        rst_n = 1'b1;
        drive(1'b1, 11'h045, 11'h07A, 11'h040, 11'h060, 4'h2, 1'b0, 1'b0, 8'h00, 1'b0);

        // Phase boundary: 15 pulses, then a pulse coincident with a valid pixel.
        for (int i = 0; i < 15; i++) cyc(1'b0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b1);
        cyc(1'b1, 11'h042, 11'h046, 11'h040, 11'h040, 4'hA, 1'b1);   // old phase 1: 3A
        cyc(1'b1, 11'h042, 11'h046, 11'h040, 11'h040, 4'hA, 1'b0);   // new phase 0: 2A

        // Drain the pipeline.
        for (int i = 0; i < 3; i++) cyc(1'b0, 11'h0, 11'h0, 11'h0, 11'h0, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
